// File: rtl/anim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : anim_pkg
// Description : Shared mode encodings and LFSR constants for the RGB ramp
//               animator.
// Revision    : 1.0 - initial release
// ============================================================================
package anim_pkg;

    // Animation mode as driven on the mode input
    typedef enum logic [1:0] {
        MODE_RUN    = 2'b00,
        MODE_FREEZE = 2'b01,
        MODE_SAW    = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    localparam int          c_LFSR_W     = 32;
    localparam int          c_TAP_A      = 32;
    localparam int          c_TAP_B      = 22;
    localparam int          c_TAP_C      = 2;
    localparam int          c_TAP_D      = 1;
    localparam logic [31:0] c_LFSR_RESET = 32'hFFFF_FFFF;

    // Step-probability exponents above 4 saturate at 4 (one nibble of LFSR)
    function automatic logic [2:0] clamp_div(input logic [2:0] d);
        return (d > 3'd4) ? 3'd4 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/anim_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : anim_lfsr
// Description : 32-bit Fibonacci LFSR with shift enable and seed load. A zero
//               seed is replaced by all-ones so the register never locks up.
// Revision    : 1.0 - initial release
// ============================================================================
module anim_lfsr
    import anim_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_shift_en,
    input  logic                i_seed_valid,
    input  logic [c_LFSR_W-1:0] i_seed,
    output logic [c_LFSR_W-1:0] o_state
);

    logic [c_LFSR_W-1:0] r_state;
    logic                w_fb;

    assign w_fb = r_state[c_TAP_A-1] ^ r_state[c_TAP_B-1] ^
                  r_state[c_TAP_C-1] ^ r_state[c_TAP_D-1];

    // Seed load takes priority over shifting; zero seed maps to all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_LFSR_RESET;
        end else if (i_seed_valid) begin
            r_state <= (i_seed == '0) ? c_LFSR_RESET : i_seed;
        end else if (i_shift_en) begin
            r_state <= {r_state[c_LFSR_W-2:0], w_fb};
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/rgb_ramp_animator.sv
`default_nettype none
// ============================================================================
// Module      : rgb_ramp_animator
// Description : Per-channel colour ramp generator advanced once per change of
//               the display scan address. Channels step randomly according
//               to an LFSR and run as triangle or sawtooth ramps.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_ramp_animator
    import anim_pkg::*;
#(
    parameter int                  NUM_CH   = 6,
    parameter int                  RES      = 24,
    parameter int                  OUT_W    = 8,
    parameter logic [3*NUM_CH-1:0] DIV_BITS = {3'd2, 3'd7, 3'd5, 3'd2, 3'd5, 3'd3}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8:0]              ram_address,
    input  logic [1:0]              mode,
    input  logic                    seed_valid,
    input  logic [31:0]             seed,
    output logic [NUM_CH*OUT_W-1:0] ram_data,
    output logic                    step_tick
);

    localparam logic [RES-1:0] c_ONE = RES'(1);

    logic [8:0]          r_addr_q;
    logic                r_adv_q;
    mode_e               w_mode;
    logic                w_step;
    logic [c_LFSR_W-1:0] w_lfsr;
    logic                w_unused_lfsr;

    assign w_mode = mode_e'(mode);

    // A step moves state only in RUN/SAW and never in a seed-load cycle
    assign w_step = r_adv_q && !seed_valid &&
                    ((w_mode == MODE_RUN) || (w_mode == MODE_SAW));

    // Address-change detector: one step enable per distinct address change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_q <= '0;
            r_adv_q  <= 1'b0;
        end else begin
            r_addr_q <= ram_address;
            r_adv_q  <= (ram_address != r_addr_q);
        end
    end

    assign step_tick = r_adv_q;

    anim_lfsr u_lfsr (
        .clk          (clk),
        .rst          (rst),
        .i_shift_en   (w_step),
        .i_seed_valid (seed_valid),
        .i_seed       (seed),
        .o_state      (w_lfsr)
    );

    // Upper LFSR bits go unused when fewer than eight channels are built
    assign w_unused_lfsr = ^w_lfsr;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            localparam logic [2:0] c_DIV  = clamp_div(DIV_BITS[3*c +: 3]);
            localparam logic [3:0] c_MASK = 4'((5'd1 << c_DIV) - 5'd1);

            logic [RES-1:0] r_acc;
            logic           r_dir_up;
            logic           w_hit;

            assign w_hit = ((w_lfsr[4*c +: 4] & c_MASK) == 4'd0);

            // Channel ramp: CLEAR wins every cycle, otherwise move on a hit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc    <= '0;
                    r_dir_up <= 1'b1;
                end else if (w_mode == MODE_CLEAR) begin
                    r_acc    <= '0;
                    r_dir_up <= 1'b1;
                end else if (w_step && w_hit) begin
                    if (w_mode == MODE_SAW) begin
                        r_acc    <= r_acc + c_ONE;
                        r_dir_up <= 1'b1;
                    end else if (r_dir_up) begin
                        if (r_acc == '1) begin
                            r_acc    <= r_acc - c_ONE;
                            r_dir_up <= 1'b0;
                        end else begin
                            r_acc <= r_acc + c_ONE;
                        end
                    end else begin
                        if (r_acc == '0) begin
                            r_acc    <= c_ONE;
                            r_dir_up <= 1'b1;
                        end else begin
                            r_acc <= r_acc - c_ONE;
                        end
                    end
                end
            end

            assign ram_data[c*OUT_W +: OUT_W] = r_acc[RES-1 -: OUT_W];
        end
    endgenerate

endmodule
`default_nettype wire
